// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl
// Sequencing controller for the ASCON permutation datapath. It accepts one
// permutation request at a time and issues one round per clock. The first
// round selects the external state (select_o=1). Each later round feeds back
// the registered permutation state. done_o marks the cycle in which the
// permutation output register holds the final state.
//
// Ports
//   clock_i      in   clock, rising edge
//   resetb_i     in   asynchronous active-low reset
//   start_i      in   run request, accepted when start_i=1 and ready_o=1
//   mode_i[1:0]  in   00=p12, 01=p8, 10=p6, 11=reserved (runs as p12, err_o)
//   abort_i      in   synchronous abort back to IDLE, suppresses done_o
//   ready_o      out  high only in IDLE
//   busy_o       out  high in LOAD and RUN
//   select_o     out  permutation select_i, high only in LOAD
//   round_o      out  permutation round_i
//   done_o       out  one-cycle pulse, permutation output is final
//   err_o        out  one-cycle pulse, the cycle after accepting mode 11
//
// Optional feature, macro ASCON_PERM_CTRL_STATS_EN:
//   stats_clr_i        in   synchronous clear of perm_count_o
//   perm_count_o[15:0] out  saturating count of done_o pulses
module ascon_perm_ctrl #(
    parameter int ROUND_W       = 4,
    parameter int NB_ROUNDS_MAX = 12
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               abort_i,
`ifdef ASCON_PERM_CTRL_STATS_EN
    input  logic               stats_clr_i,
    output logic [15:0]        perm_count_o,
`endif
    output logic               ready_o,
    output logic               busy_o,
    output logic               select_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [ROUND_W-1:0] NB_R      = ROUND_W'(NB_ROUNDS_MAX);
    localparam logic [ROUND_W-1:0] LAST_R    = ROUND_W'(NB_ROUNDS_MAX - 1);
    localparam logic [ROUND_W-1:0] ONE_R     = ROUND_W'(1);

    state_t             state_reg, state_next;
    logic [ROUND_W-1:0] cnt_reg, cnt_next;   // round index of the current cycle
    logic [ROUND_W-1:0] a_reg, a_next;       // latched round count
    logic               err_reg, err_next;

    // Mode 11 is reserved and falls back to the full 12-round permutation.
    function automatic logic [ROUND_W-1:0] mode_rounds(input logic [1:0] m);
        case (m)
            2'b01:   return ROUND_W'(8);
            2'b10:   return ROUND_W'(6);
            default: return NB_R;
        endcase
    endfunction

    // State register
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic. abort_i overrides everything, including an accept.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        err_next   = 1'b0;
        if (abort_i) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        a_next     = mode_rounds(mode_i);
                        cnt_next   = NB_R - mode_rounds(mode_i);
                        err_next   = (mode_i == 2'b11);
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    cnt_next   = cnt_reg + ONE_R;
                    state_next = RUN;
                end
                RUN: begin
                    // Clear on the last round so the counter never reaches 12.
                    if (cnt_reg == LAST_R) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next   = cnt_reg + ONE_R;
                    end
                end
                default: state_next = IDLE;   // DONE
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        ready_o  = (state_reg == IDLE);
        busy_o   = (state_reg == LOAD) || (state_reg == RUN);
        select_o = (state_reg == LOAD);
        done_o   = (state_reg == DONE);
        err_o    = err_reg;
        case (state_reg)
            LOAD:    round_o = NB_R - a_reg;
            RUN:     round_o = cnt_reg;
            default: round_o = '0;
        endcase
    end

`ifdef ASCON_PERM_CTRL_STATS_EN
    logic [15:0] perm_count_reg;

    // A clear in the same cycle as done_o takes priority over the increment.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            perm_count_reg <= '0;
        end else if (stats_clr_i) begin
            perm_count_reg <= '0;
        end else if ((state_reg == DONE) && (perm_count_reg != 16'hFFFF)) begin
            perm_count_reg <= perm_count_reg + 16'd1;
        end
    end

    assign perm_count_o = perm_count_reg;
`endif

    cnt_range_a: assert property (@(posedge clock_i) disable iff (!resetb_i) cnt_reg < NB_R);

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Testbench for ascon_perm_ctrl: directed runs of p12, p8 and p6, a
// start_i held high across two runs, aborts, reserved mode, and reset mid-run.
// It then runs randomized requests, some with aborts. The expected output of
// every cycle comes from the cycle position within a run and the round count.
module tb_ascon_perm_ctrl;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic [1:0] mode_i;
    logic       abort_i;
    logic       ready_o, busy_o, select_o, done_o, err_o;
    logic [3:0] round_o;
`ifdef ASCON_PERM_CTRL_STATS_EN
    logic        stats_clr_i;
    logic [15:0] perm_count_o;
    int          exp_perm;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock_i = ~clock_i;

    ascon_perm_ctrl dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .abort_i  (abort_i),
`ifdef ASCON_PERM_CTRL_STATS_EN
        .stats_clr_i  (stats_clr_i),
        .perm_count_o (perm_count_o),
`endif
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .select_o (select_o),
        .round_o  (round_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    // Bit order {ready, busy, select, done, err, round[3:0]}
    function automatic logic [8:0] observed();
        return {ready_o, busy_o, select_o, done_o, err_o, round_o};
    endfunction

    function automatic int rounds_of(input logic [1:0] m);
        if (m == 2'b01) return 8;
        if (m == 2'b10) return 6;
        return 12;
    endfunction

    // Reference for cycle k after the accept edge of a run of a rounds.
    // k=0 means IDLE, 1 is the load round, 2..a are feedback rounds, and a+1 is done.
    function automatic logic [8:0] expected(input int k, input int a, input bit e);
        logic [3:0] r;
        if (k == 0) return 9'b1_0000_0000;
        if (k == 1) begin
            r = 4'(12 - a);
            return {4'b0110, e, r};
        end
        if (k <= a) begin
            r = 4'(12 - a + k - 1);
            return {5'b01000, r};
        end
        return 9'b0_0010_0000;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock, then check IDLE; abort_i is dropped after the edge.
    task automatic idle_step(input string tag);
        @(posedge clock_i); #1;
        abort_i = 1'b0;
        chk(tag, observed(), expected(0, 0, 0));
`ifdef ASCON_PERM_CTRL_STATS_EN
        tests++;
        assert (perm_count_o === 16'(exp_perm)) else begin
            fails++;
            $error("FAIL %s_count: observed %h expected %h", tag, perm_count_o, 16'(exp_perm));
        end
`endif
        $display("[TB] %s idle ready=%0b", tag, ready_o);
    endtask

    // Accept one request and check every cycle through done (or the abort cycle).
    // The task ends in the last checked cycle, so the caller follows with idle_step.
    task automatic run_perm(input string tag, input logic [1:0] mode,
                            input int abort_k, input bit keep_start);
        int a;
        bit e;
        a = rounds_of(mode);
        e = (mode == 2'b11);
        start_i = 1'b1;
        mode_i  = mode;
        @(posedge clock_i); #1;
        if (!keep_start) start_i = 1'b0;
        mode_i = 2'($urandom_range(0, 3));   // must not affect the running permutation
        for (int k = 1; k <= a + 1; k++) begin
            chk($sformatf("%s_k%0d", tag, k), observed(), expected(k, a, e));
            if (k == abort_k) begin
                abort_i = 1'b1;
                break;
            end
`ifdef ASCON_PERM_CTRL_STATS_EN
            if (k == a + 1) exp_perm++;
`endif
            if (k <= a) begin
                @(posedge clock_i); #1;
            end
        end
        $display("[TB] %s mode=%0d rounds=%0d abort_k=%0d", tag, mode, a, abort_k);
    endtask

    initial begin
        resetb_i = 1'b0;
        start_i  = 1'b0;
        mode_i   = 2'b00;
        abort_i  = 1'b0;
`ifdef ASCON_PERM_CTRL_STATS_EN
        stats_clr_i = 1'b0;
        exp_perm    = 0;
`endif
        #12;
        chk("reset", observed(), expected(0, 0, 0));
        @(negedge clock_i);
        resetb_i = 1'b1;
        idle_step("post_reset");

        // Directed runs of each permutation length
        run_perm("p12", 2'b00, 0, 1'b0);
        idle_step("p12_end");
        run_perm("p8", 2'b01, 0, 1'b0);
        idle_step("p8_end");
        run_perm("p6", 2'b10, 0, 1'b0);
        idle_step("p6_end");

        // start_i held high: the second accept lands on the cycle-10 IDLE edge
        run_perm("p8_hold_a", 2'b01, 0, 1'b1);
        idle_step("p8_hold_gap");
        run_perm("p8_hold_b", 2'b01, 0, 1'b0);
        idle_step("p8_hold_end");
        idle_step("p8_hold_quiet");

        // Abort in cycle 5 of a p12 run
        run_perm("p12_abort", 2'b00, 5, 1'b0);
        idle_step("p12_abort_idle");

        // Abort together with start in IDLE: no accept
        start_i = 1'b1;
        abort_i = 1'b1;
        idle_step("abort_in_idle");
        start_i = 1'b0;
        idle_step("abort_in_idle_2");

        // Reserved mode runs as p12 with an err_o pulse
        run_perm("mode11", 2'b11, 0, 1'b0);
        idle_step("mode11_end");

        // Reset in cycle 4 of a run: outputs return to reset values at once
        start_i = 1'b1;
        mode_i  = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock_i); #1;
            start_i = 1'b0;
        end
        chk("pre_reset_k4", observed(), expected(4, 12, 0));
        resetb_i = 1'b0;
        #1;
        chk("mid_reset", observed(), expected(0, 0, 0));
`ifdef ASCON_PERM_CTRL_STATS_EN
        exp_perm = 0;
`endif
        #1;
        resetb_i = 1'b1;
        idle_step("after_mid_reset");

        // Randomized requests, some aborted, with random idle gaps
        for (int i = 0; i < 24; i++) begin
            logic [1:0] m;
            int ak;
            int gap;
            m   = 2'($urandom_range(0, 3));
            ak  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rounds_of(m)) : 0;
            gap = $urandom_range(0, 2);
            run_perm($sformatf("rnd%0d", i), m, ak, 1'b0);
            idle_step($sformatf("rnd%0d_end", i));
            for (int g = 0; g < gap; g++) idle_step($sformatf("rnd%0d_gap", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
- Sequencing controller that drives the ASCON permutation datapath's select_i and round_i inputs.
- Accepts a start request with a round-count mode and issues one round per cycle.
  - First round loads the external state (select=1); later rounds feed back the registered state.
- Flags the cycle in which the permutation output register holds the final state.
- Sits between the top-level ASCON mode FSM (initialisation, associated data, plaintext, finalisation) and the permutation.

Parameters:
- ROUND_W, 4, width of round_o; fixed to the permutation's round_i width.
- NB_ROUNDS_MAX, 12, total round-constant count; first round index is NB_ROUNDS_MAX minus rounds requested.

Ports:
- clock_i  input  1  clock, rising edge.
- resetb_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request to run one permutation; accepted when start_i=1 and ready_o=1 at a rising edge.
- mode_i  input  2  round count, sampled at accept: 00=p12, 01=p8, 10=p6, 11=reserved (runs as p12, err_o pulses).
- abort_i  input  1  synchronous abort; returns to IDLE with no done_o.
- ready_o  output  1  1 only in IDLE.
- busy_o  output  1  1 in LOAD and RUN.
- select_o  output  1  to permutation select_i; 1 only in LOAD.
- round_o  output  4  to permutation round_i.
- done_o  output  1  one-cycle pulse; permutation_o holds the final state in this cycle.
- err_o  output  1  one-cycle pulse, the cycle after accepting mode 11.

Behaviour:
- Reset (async, resetb_i=0):
  - state=IDLE.
  - ready_o=1; busy_o, select_o, done_o, err_o=0; round_o=0.
  - Latched round count a=0; round counter=0.
- States: IDLE, LOAD, RUN, DONE. All outputs are decoded from registered state and counter; there is no combinational path from any input to any output.
- IDLE:
  - ready_o=1, select_o=0, round_o=0.
  - On accept: latch a (12/8/6), load counter with 12-a, go to LOAD.
- LOAD (exactly 1 cycle):
  - select_o=1, round_o=12-a, busy_o=1.
  - The upstream must hold the state valid on the permutation input during this cycle.
  - Counter increments. Next state is RUN.
- RUN:
  - select_o=0, round_o=counter, busy_o=1. Counter increments each cycle.
  - When round_o=11, next state is DONE.
  - RUN lasts a-1 cycles.
- DONE (exactly 1 cycle):
  - done_o=1, busy_o=0, ready_o=0, select_o=0, round_o=0.
  - Next state is IDLE.
- Latency, with the accept at edge 0:
  - LOAD is cycle 1; RUN is cycles 2..a; done_o is high in cycle a+1.
  - p12: done at cycle 13. p8: cycle 9. p6: cycle 7.
  - Round sequence: p12 = 0..11; p8 = 4..11; p6 = 6..11.
- Minimum spacing between accepts is a+2 cycles.
  - start_i in LOAD, RUN or DONE is ignored (not queued).
  - The requester must hold start_i until ready_o=1.
- abort_i:
  - Takes priority in any state: next state is IDLE, counter cleared, no done_o.
  - In IDLE it takes priority over start_i, so no accept occurs.
- Counter is 4 bits and never exceeds 11; reaching 12+ is an assertion failure.
- mode_i changes after accept have no effect on the current run.
- Reset mid-run: immediately returns to IDLE outputs; no done_o.
- The permutation register updates every cycle; data outside DONE is don't-care for consumers.

Optional Feature:
- Macro ASCON_PERM_CTRL_STATS_EN.
- Defined:
  - Adds output perm_count_o [15:0], a saturating count of done_o pulses (holds at 0xFFFF).
  - Adds input stats_clr_i: synchronous clear to 0.
  - If stats_clr_i and done_o occur in the same cycle, clear wins.
  - Async reset value is 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset then p12 start (mode 00) at edge 0 -> select_o=1 only in cycle 1; round_o 0,1,…,11 in cycles 1..12; done_o=1 only in cycle 13; ready_o=1 in cycle 14.
- p6 with permutation attached, input state = ASCON-128 init vector: key=0, nonce=0 -> round_o 6..11; permutation_o at done_o matches the reference model of p6.
- p8 start, then start_i held high continuously -> second accept happens at ready_o (cycle 10); done_o at cycles 9 and 19; no extra runs.
- abort_i=1 in cycle 5 of a p12 run -> IDLE at cycle 6; no done_o; ready_o=1. abort_i with start_i in IDLE -> no accept.
- mode 11 -> err_o pulse in cycle 1; p12 round sequence 0..11; done_o at cycle 13. resetb_i low in cycle 4 -> all outputs at reset values immediately.
- STATS_EN: 3 runs -> perm_count_o=3; stats_clr_i coincident with done_o -> 0; preload 0xFFFE, then 2 runs -> 0xFFFF.
